// File: rtl/seg7_pattern_encoder.sv
// Recovers the 3-bit code from a sampled 7-segment pattern (a..g), with
// synchronization, stability filtering, table validation and valid/ready output.
module seg7_pattern_encoder #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       a,
   input  logic       b,
   input  logic       c,
   input  logic       d,
   input  logic       e,
   input  logic       f,
   input  logic       g,
   output logic       c0,
   output logic       c1,
   output logic       c2,
   output logic       err,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] err_cnt
);

   typedef enum logic [1:0] {IDLE, SETTLE, OUT} state_t;

   typedef struct packed {
      logic [2:0] code;
      logic       err;
   } res_t;

   localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

   state_t     state, state_nxt;
   logic [6:0] pat_m, seg_s;
   logic [6:0] last_pat, cand;
   logic [7:0] cnt;
   res_t       res_q;
   res_t       res_lk;
   logic       settled;

   function automatic res_t lookup(input logic [6:0] p);
      res_t r;
      r = '{code: 3'b000, err: 1'b0};
      case (p)
         7'b1111110: r.code = 3'b000;
         7'b0110000: r.code = 3'b001;
         7'b1101101: r.code = 3'b010;
         7'b1111001: r.code = 3'b011;
         7'b0110011: r.code = 3'b100;
         7'b1011011: r.code = 3'b101;
         7'b1011111: r.code = 3'b110;
         7'b1110000: r.code = 3'b111;
         default:    r.err  = 1'b1;
      endcase
      return r;
   endfunction

   assign res_lk  = lookup(cand);
   assign settled = (seg_s == cand) && (cnt == CNT_LAST);

   // Pins are asynchronous to clk; two flops before anything looks at them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat_m <= '0;
         seg_s <= '0;
      end else begin
         pat_m <= {a, b, c, d, e, f, g};
         seg_s <= pat_m;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (seg_s != last_pat) state_nxt = SETTLE;
         SETTLE:  if (settled) state_nxt = (cand == 7'b0) ? IDLE : OUT;
         OUT:     if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      out_valid = (state == OUT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_pat <= '0;
         cand     <= '0;
         cnt      <= '0;
         res_q    <= '0;
         err_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (seg_s != last_pat) begin
                  cand <= seg_s;
                  cnt  <= '0;
               end
            end
            SETTLE: begin
               if (seg_s != cand) begin
                  cand <= seg_s;
                  cnt  <= '0;
               end else if (cnt == CNT_LAST) begin
                  last_pat <= cand;
                  // Blank lines update last_pat but never emit a result.
                  if (cand != 7'b0) begin
                     res_q <= res_lk;
                     if (res_lk.err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign {c2, c1, c0} = res_q.code;
   assign err          = res_q.err;

endmodule
